// File: rtl/microcode_pkg.sv
// Shared widths, control-word bit positions and built-in table patterns for the microcode store.
package microcode_pkg;

  localparam int DEC_AW  = 4;
  localparam int DEC_DW  = 8;
  localparam int CTRL_AW = 8;
  localparam int CTRL_DW = 16;

  // Control word A bit positions
  localparam int UPC_RST  = 0;
  localparam int IR_LATCH = 3;
  localparam int DEC_SEL  = 4;
  localparam int DEC_A3   = 5;
  localparam int ROM_RD   = 6;
  localparam int ROM_CS   = 7;

  // Control word B bit positions
  localparam int SEL_SP  = 0;
  localparam int BUF_CAR = 2;
  localparam int AC_BUS  = 3;
  localparam int AC_CAR  = 4;
  localparam int REG_BUS = 5;
  localparam int REG_CAR = 6;
  localparam int RAM_RD  = 7;
  localparam int RAM_WR  = 8;
  localparam int RAM_CS  = 9;
  localparam int IN_BUS  = 10;
  localparam int OUT_CAR = 11;

  typedef enum logic [1:0] {
    PAT_DEC = 2'd0,
    PAT_A   = 2'd1,
    PAT_B   = 2'd2
  } pat_e;

  typedef enum logic [1:0] {
    SEL_DEC  = 2'd0,
    SEL_A    = 2'd1,
    SEL_B    = 2'd2,
    SEL_NONE = 2'd3
  } wr_sel_e;

  // Built-in power-up contents; callers truncate to their table width.
  function automatic logic [31:0] pattern_word(pat_e pat, int unsigned idx);
    logic [7:0] b;
    b = idx[7:0];
    case (pat)
      PAT_DEC: pattern_word = 32'h10 | {28'h0, b[3:0]};
      PAT_A:   pattern_word = {16'h0, b, ~b};
      PAT_B:   pattern_word = {16'h0, ~b, b};
      default: pattern_word = 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/ucode_table.sv
// Generic 2**AW x DW table with registered read, async-cleared output and optional write port
// (write port present when MICROCODE_WR_EN is defined).
module ucode_table #(
  parameter int                 AW        = 8,
  parameter int                 DW        = 16,
  parameter microcode_pkg::pat_e PATTERN  = microcode_pkg::PAT_A,
  parameter string              INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [AW-1:0] rd_addr,
`ifdef MICROCODE_WR_EN
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
`endif
  output logic [DW-1:0] rd_data
);
  import microcode_pkg::*;

  localparam int DEPTH = 2 ** AW;

  typedef logic [DW-1:0] mem_t [DEPTH];

  function automatic mem_t init_mem();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) begin
      m[i] = DW'(pattern_word(PATTERN, i));
    end
    return m;
  endfunction

  mem_t mem = init_mem();

`ifdef MICROCODE_WR_EN
  // Same-edge read sees the pre-write word, giving read-before-write.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (en) begin
      rd_data <= mem[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: rtl/microcode_store.sv
// Decode table plus two-half control store with one-cycle registered lookup.
// Optional runtime write port enabled by defining MICROCODE_WR_EN.
module microcode_store #(
  parameter int    DEC_AW        = 4,
  parameter int    DEC_DW        = 8,
  parameter int    CTRL_AW       = 8,
  parameter int    CTRL_DW       = 16,
  parameter string DEC_INIT_FILE = "",
  parameter string CA_INIT_FILE  = "",
  parameter string CB_INIT_FILE  = ""
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [DEC_AW-1:0]  dec_addr,
  input  logic [CTRL_AW-1:0] ctrl_addr,
`ifdef MICROCODE_WR_EN
  input  logic               wr_en,
  input  logic [1:0]         wr_sel,
  input  logic [CTRL_AW-1:0] wr_addr,
  input  logic [CTRL_DW-1:0] wr_data,
`endif
  output logic [DEC_DW-1:0]  dec_data,
  output logic [CTRL_DW-1:0] ctrl_a_data,
  output logic [CTRL_DW-1:0] ctrl_b_data,
  output logic               data_valid
);
  import microcode_pkg::*;

`ifdef MICROCODE_WR_EN
  logic wr_dec;
  logic wr_a;
  logic wr_b;

  assign wr_dec = wr_en && (wr_sel == SEL_DEC);
  assign wr_a   = wr_en && (wr_sel == SEL_A);
  assign wr_b   = wr_en && (wr_sel == SEL_B);
`endif

  ucode_table #(
    .AW(DEC_AW), .DW(DEC_DW), .PATTERN(PAT_DEC), .INIT_FILE(DEC_INIT_FILE)
  ) u_dec (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .rd_addr (dec_addr),
`ifdef MICROCODE_WR_EN
    .wr_en   (wr_dec),
    .wr_addr (wr_addr[DEC_AW-1:0]),
    .wr_data (wr_data[DEC_DW-1:0]),
`endif
    .rd_data (dec_data)
  );

  ucode_table #(
    .AW(CTRL_AW), .DW(CTRL_DW), .PATTERN(PAT_A), .INIT_FILE(CA_INIT_FILE)
  ) u_ctrl_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .rd_addr (ctrl_addr),
`ifdef MICROCODE_WR_EN
    .wr_en   (wr_a),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
`endif
    .rd_data (ctrl_a_data)
  );

  ucode_table #(
    .AW(CTRL_AW), .DW(CTRL_DW), .PATTERN(PAT_B), .INIT_FILE(CB_INIT_FILE)
  ) u_ctrl_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .rd_addr (ctrl_addr),
`ifdef MICROCODE_WR_EN
    .wr_en   (wr_b),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
`endif
    .rd_data (ctrl_b_data)
  );

  // Valid tracks the select of the previous edge, so it lines up with the table outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_valid <= 1'b0;
    end else begin
      data_valid <= en;
    end
  end

endmodule

// File: tb/tb_microcode_store.sv
// Directed bench for microcode_store; covers the write port when MICROCODE_WR_EN is defined.
module tb_microcode_store;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [3:0]  dec_addr;
  logic [7:0]  ctrl_addr;
`ifdef MICROCODE_WR_EN
  logic        wr_en;
  logic [1:0]  wr_sel;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
`endif
  logic [7:0]  dec_data;
  logic [15:0] ctrl_a_data;
  logic [15:0] ctrl_b_data;
  logic        data_valid;

  int errors = 0;
  int checks = 0;

  microcode_store dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .dec_addr    (dec_addr),
    .ctrl_addr   (ctrl_addr),
`ifdef MICROCODE_WR_EN
    .wr_en       (wr_en),
    .wr_sel      (wr_sel),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
`endif
    .dec_data    (dec_data),
    .ctrl_a_data (ctrl_a_data),
    .ctrl_b_data (ctrl_b_data),
    .data_valid  (data_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b1;
    dec_addr = 4'hA;
    ctrl_addr = 8'h3C;
    #2;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({dec_data, ctrl_a_data, ctrl_b_data, data_valid} !== 41'h0) begin
        errors++;
        $display("FAIL reset cyc%0d: dec=%h a=%h b=%h v=%b, required all 0", i, dec_data, ctrl_a_data, ctrl_b_data, data_valid);
      end else
        $display("reset cyc%0d: outputs 0", i);
    end
  endtask

  task automatic test_first_read();
    rst_n = 1'b1;
    en = 1'b1;
    dec_addr = 4'hA;
    ctrl_addr = 8'h3C;
    tick();
    checks++;
    if (dec_data !== 8'h1A || ctrl_a_data !== 16'h3CC3 || ctrl_b_data !== 16'hC33C || data_valid !== 1'b1) begin
      errors++;
      $display("FAIL first_read: dec=%h a=%h b=%h v=%b, required 1a 3cc3 c33c 1", dec_data, ctrl_a_data, ctrl_b_data, data_valid);
    end else
      $display("first_read: dec=%h a=%h b=%h v=%b", dec_data, ctrl_a_data, ctrl_b_data, data_valid);
  endtask

  task automatic test_sweep();
    logic [7:0]  a;
    logic [7:0]  exp_dec;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    int sweep_bad = 0;
    en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      a = i[7:0];
      ctrl_addr = a;
      dec_addr = a[3:0];
      exp_dec = {4'h1, a[3:0]};
      exp_a = {a, ~a};
      exp_b = {~a, a};
      tick();
      checks++;
      if (dec_data !== exp_dec || ctrl_a_data !== exp_a || ctrl_b_data !== exp_b || data_valid !== 1'b1) begin
        errors++;
        sweep_bad++;
        $display("FAIL sweep addr=%h: dec=%h a=%h b=%h v=%b, required %h %h %h 1", a, dec_data, ctrl_a_data, ctrl_b_data, data_valid, exp_dec, exp_a, exp_b);
      end
    end
    $display("sweep: 256 addresses, %0d bad", sweep_bad);
    checks++;
    if (ctrl_a_data !== 16'hFF00 || ctrl_b_data !== 16'h00FF) begin
      errors++;
      $display("FAIL sweep_top: a=%h b=%h, required ff00 00ff", ctrl_a_data, ctrl_b_data);
    end else
      $display("sweep_top: a=%h b=%h", ctrl_a_data, ctrl_b_data);
  endtask

  task automatic test_deselect();
    en = 1'b1;
    dec_addr = 4'h5;
    ctrl_addr = 8'h05;
    tick();
    checks++;
    if (dec_data !== 8'h15 || ctrl_a_data !== 16'h05FA || ctrl_b_data !== 16'hFA05 || data_valid !== 1'b1) begin
      errors++;
      $display("FAIL desel_pre: dec=%h a=%h b=%h v=%b, required 15 05fa fa05 1", dec_data, ctrl_a_data, ctrl_b_data, data_valid);
    end else
      $display("desel_pre: dec=%h a=%h b=%h v=%b", dec_data, ctrl_a_data, ctrl_b_data, data_valid);
    en = 1'b0;
    dec_addr = 4'h7;
    ctrl_addr = 8'h77;
    tick();
    checks++;
    if ({dec_data, ctrl_a_data, ctrl_b_data, data_valid} !== 41'h0) begin
      errors++;
      $display("FAIL desel_idle: dec=%h a=%h b=%h v=%b, required all 0", dec_data, ctrl_a_data, ctrl_b_data, data_valid);
    end else
      $display("desel_idle: outputs 0");
    en = 1'b1;
    tick();
    checks++;
    if (dec_data !== 8'h17 || ctrl_a_data !== 16'h7788 || ctrl_b_data !== 16'h8877 || data_valid !== 1'b1) begin
      errors++;
      $display("FAIL desel_post: dec=%h a=%h b=%h v=%b, required 17 7788 8877 1", dec_data, ctrl_a_data, ctrl_b_data, data_valid);
    end else
      $display("desel_post: dec=%h a=%h b=%h v=%b", dec_data, ctrl_a_data, ctrl_b_data, data_valid);
  endtask

  task automatic test_async_reset();
    en = 1'b1;
    dec_addr = 4'hC;
    ctrl_addr = 8'hC3;
    tick();
    checks++;
    if (ctrl_a_data !== 16'hC33C || data_valid !== 1'b1) begin
      errors++;
      $display("FAIL arst_pre: a=%h v=%b, required c33c 1", ctrl_a_data, data_valid);
    end else
      $display("arst_pre: a=%h v=%b", ctrl_a_data, data_valid);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({dec_data, ctrl_a_data, ctrl_b_data, data_valid} !== 41'h0) begin
      errors++;
      $display("FAIL arst_mid: dec=%h a=%h b=%h v=%b, required all 0", dec_data, ctrl_a_data, ctrl_b_data, data_valid);
    end else
      $display("arst_mid: outputs 0 before next edge");
    #2;
    rst_n = 1'b1;
    tick();
    checks++;
    if (dec_data !== 8'h1C || ctrl_a_data !== 16'hC33C || ctrl_b_data !== 16'h3CC3 || data_valid !== 1'b1) begin
      errors++;
      $display("FAIL arst_post: dec=%h a=%h b=%h v=%b, required 1c c33c 3cc3 1", dec_data, ctrl_a_data, ctrl_b_data, data_valid);
    end else
      $display("arst_post: dec=%h a=%h b=%h v=%b", dec_data, ctrl_a_data, ctrl_b_data, data_valid);
  endtask

`ifdef MICROCODE_WR_EN
  task automatic test_write();
    en = 1'b1;
    ctrl_addr = 8'h3C;
    dec_addr = 4'h3;
    wr_en = 1'b1;
    wr_sel = 2'd1;
    wr_addr = 8'h3C;
    wr_data = 16'hBEEF;
    tick();
    wr_en = 1'b0;
    checks++;
    if (ctrl_a_data !== 16'h3CC3 || ctrl_b_data !== 16'hC33C) begin
      errors++;
      $display("FAIL wr_old: a=%h b=%h, required 3cc3 c33c", ctrl_a_data, ctrl_b_data);
    end else
      $display("wr_old: a=%h b=%h", ctrl_a_data, ctrl_b_data);
    tick();
    checks++;
    if (ctrl_a_data !== 16'hBEEF || ctrl_b_data !== 16'hC33C || dec_data !== 8'h13) begin
      errors++;
      $display("FAIL wr_new: a=%h b=%h dec=%h, required beef c33c 13", ctrl_a_data, ctrl_b_data, dec_data);
    end else
      $display("wr_new: a=%h b=%h dec=%h", ctrl_a_data, ctrl_b_data, dec_data);
    // Decode write with en low, then read back.
    en = 1'b0;
    wr_en = 1'b1;
    wr_sel = 2'd0;
    wr_addr = 8'hF3;
    wr_data = 16'h1255;
    tick();
    wr_en = 1'b0;
    en = 1'b1;
    tick();
    checks++;
    if (dec_data !== 8'h55) begin
      errors++;
      $display("FAIL wr_dec: dec=%h, required 55", dec_data);
    end else
      $display("wr_dec: dec=%h", dec_data);
  endtask
`endif

  initial begin
`ifdef MICROCODE_WR_EN
    wr_en = 1'b0;
    wr_sel = 2'd3;
    wr_addr = 8'h00;
    wr_data = 16'h0000;
`endif
    test_reset();
    test_first_read();
    test_sweep();
    test_deselect();
    test_async_reset();
`ifdef MICROCODE_WR_EN
    test_write();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
